// File: rtl/systolic_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// systolic_ctrl_pkg: shared types and defaults for the tile sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package systolic_ctrl_pkg;

   localparam int CMD_K_W           = 16;
   localparam int CMD_PASS_W        = 8;
   localparam int CMD_ADDR_W        = 16;
   localparam int DEF_FILL_LATENCY  = 32 + 16 + 2;
   localparam int DEF_QUANT_TIMEOUT = 64;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_QUANT  = 3'd4,
      S_RESP   = 3'd5
   } seq_state_e;

   typedef struct packed {
      logic [CMD_K_W-1:0]    k;
      logic [CMD_PASS_W-1:0] passes;
      logic [CMD_ADDR_W-1:0] base;
      logic [31:0]           scale;
      logic [7:0]            shift;
   } tile_cmd_t;

endpackage

`default_nettype wire

// File: rtl/systolic_tile_sequencer_if.sv
// ----------------------------------------------------------------------------
// systolic_tile_sequencer_if: command, array-control and response signals.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface systolic_tile_sequencer_if #(
   parameter int K_WIDTH    = 16,
   parameter int PASS_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [K_WIDTH-1:0]    cmd_k;
   logic [PASS_WIDTH-1:0] cmd_passes;
   logic [ADDR_WIDTH-1:0] cmd_base_addr;
   logic [31:0]           cmd_scale;
   logic [7:0]            cmd_shift;
   logic                  op_rd_en;
   logic [ADDR_WIDTH-1:0] op_rd_addr;
   logic                  arr_enable;
   logic                  accum_clear;
   logic                  accum_enable;
   logic                  quant_enable;
   logic [31:0]           scale_factor;
   logic [7:0]            shift_amount;
   logic                  systolic_valid;
   logic                  accum_overflow;
   logic                  quant_valid;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_overflow;
   logic                  rsp_error;
   logic                  busy;

   // Host / array environment side
   modport master (
      output cmd_valid, cmd_k, cmd_passes, cmd_base_addr, cmd_scale, cmd_shift,
      output systolic_valid, accum_overflow, quant_valid, rsp_ready,
      input  cmd_ready, op_rd_en, op_rd_addr, arr_enable, accum_clear,
      input  accum_enable, quant_enable, scale_factor, shift_amount,
      input  rsp_valid, rsp_overflow, rsp_error, busy
   );

   // Sequencer side
   modport slave (
      input  cmd_valid, cmd_k, cmd_passes, cmd_base_addr, cmd_scale, cmd_shift,
      input  systolic_valid, accum_overflow, quant_valid, rsp_ready,
      output cmd_ready, op_rd_en, op_rd_addr, arr_enable, accum_clear,
      output accum_enable, quant_enable, scale_factor, shift_amount,
      output rsp_valid, rsp_overflow, rsp_error, busy
   );
endinterface

`default_nettype wire

// File: rtl/systolic_addr_gen.sv
// ----------------------------------------------------------------------------
// systolic_addr_gen: loadable operand address counter with K-beat terminal flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module systolic_addr_gen #(
   parameter int ADDR_WIDTH = 16,
   parameter int K_WIDTH    = 16
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  load,
   input  wire logic [ADDR_WIDTH-1:0] base,
   input  wire logic                  step,
   input  wire logic [K_WIDTH-1:0]    k_term,
   output logic      [ADDR_WIDTH-1:0] addr,
   output logic                       k_last
);
   logic [K_WIDTH-1:0] k_cnt;

   assign k_last = (k_cnt == k_term);

   // The address keeps running across passes; only the beat counter rewinds.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr  <= '0;
         k_cnt <= '0;
      end else if (load) begin
         addr  <= base;
         k_cnt <= '0;
      end else if (step) begin
         addr  <= addr + ADDR_WIDTH'(1);
         k_cnt <= k_last ? '0 : k_cnt + K_WIDTH'(1);
      end
   end
endmodule

`default_nettype wire

// File: rtl/systolic_tile_sequencer.sv
// ----------------------------------------------------------------------------
// systolic_tile_sequencer: per-command clear/stream/drain/quant/respond control.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module systolic_tile_sequencer
   import systolic_ctrl_pkg::*;
#(
   parameter int ROWS          = 32,
   parameter int COLS          = 16,
   parameter int K_WIDTH       = CMD_K_W,
   parameter int PASS_WIDTH    = CMD_PASS_W,
   parameter int ADDR_WIDTH    = CMD_ADDR_W,
   parameter int FILL_LATENCY  = ROWS + COLS + 2,
   parameter int QUANT_TIMEOUT = DEF_QUANT_TIMEOUT
) (
   input wire logic                  clk,
   input wire logic                  reset,
   systolic_tile_sequencer_if.slave  bus
);
   localparam int DRAIN_CYCLES = FILL_LATENCY + 2;
   localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
   localparam int WAIT_W       = $clog2(QUANT_TIMEOUT + 1);

   seq_state_e            state, next_state;
   tile_cmd_t             cmd;
   logic [PASS_WIDTH-1:0] pass_cnt;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [K_WIDTH-1:0]    k_term;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  k_last, drain_last, last_pass, wait_last, bad_cmd;
   logic                  ready, rd_en, arr_en, clr, acc_en, q_en;
   logic                  rsp_vld, ovf, err, active;
   logic                  unused_ok;

   assign unused_ok  = bus.systolic_valid;
   assign k_term     = cmd.k - CMD_K_W'(1);
   assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));
   assign last_pass  = (pass_cnt == cmd.passes - CMD_PASS_W'(1));
   assign wait_last  = (wait_cnt == WAIT_W'(QUANT_TIMEOUT - 1));
   assign bad_cmd    = (bus.cmd_k == '0) || (bus.cmd_passes == '0);

   systolic_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .K_WIDTH    (K_WIDTH)
   ) u_addr_gen (
      .clk    (clk),
      .reset  (reset),
      .load   (state == S_CLEAR),
      .base   (cmd.base),
      .step   (state == S_STREAM),
      .k_term (k_term),
      .addr   (rd_addr),
      .k_last (k_last)
   );

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (bus.cmd_valid && ready) next_state = bad_cmd ? S_RESP : S_CLEAR;
         S_CLEAR:  next_state = S_STREAM;
         S_STREAM: if (k_last) next_state = S_DRAIN;
         S_DRAIN:  if (drain_last) next_state = last_pass ? S_QUANT : S_STREAM;
         S_QUANT:  if (bus.quant_valid || wait_last) next_state = S_RESP;
         S_RESP:   if (bus.rsp_ready) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Strobes are decoded from next_state so each one lines up with its state cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cmd       <= '0;
         pass_cnt  <= '0;
         drain_cnt <= '0;
         wait_cnt  <= '0;
         ready     <= 1'b1;
         rd_en     <= 1'b0;
         arr_en    <= 1'b0;
         clr       <= 1'b0;
         acc_en    <= 1'b0;
         q_en      <= 1'b0;
         rsp_vld   <= 1'b0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         active    <= 1'b0;
      end else begin
         state   <= next_state;
         ready   <= (next_state == S_IDLE);
         active  <= (next_state != S_IDLE);
         clr     <= (next_state == S_CLEAR);
         rd_en   <= (next_state == S_STREAM);
         acc_en  <= (next_state == S_STREAM) || (next_state == S_DRAIN);
         q_en    <= (next_state == S_QUANT);
         rsp_vld <= (next_state == S_RESP);
         arr_en  <= rd_en;

         drain_cnt <= (state == S_DRAIN && !drain_last) ? drain_cnt + DRAIN_W'(1) : '0;
         wait_cnt  <= (state == S_QUANT) ? wait_cnt + WAIT_W'(1) : '0;

         if (state == S_CLEAR)
            pass_cnt <= '0;
         else if (state == S_DRAIN && drain_last && !last_pass)
            pass_cnt <= pass_cnt + PASS_WIDTH'(1);

         if (state == S_IDLE && bus.cmd_valid) begin
            cmd.k      <= bus.cmd_k;
            cmd.passes <= bus.cmd_passes;
            cmd.base   <= bus.cmd_base_addr;
            cmd.scale  <= bus.cmd_scale;
            cmd.shift  <= bus.cmd_shift;
            ovf        <= 1'b0;
            err        <= bad_cmd;
         end else begin
            if (bus.accum_overflow && (state == S_CLEAR || state == S_STREAM ||
                                       state == S_DRAIN || state == S_QUANT))
               ovf <= 1'b1;
            if (state == S_QUANT && !bus.quant_valid && wait_last)
               err <= 1'b1;
         end
      end
   end

   assign bus.cmd_ready    = ready;
   assign bus.op_rd_en     = rd_en;
   assign bus.op_rd_addr   = rd_addr;
   assign bus.arr_enable   = arr_en;
   assign bus.accum_clear  = clr;
   assign bus.accum_enable = acc_en;
   assign bus.quant_enable = q_en;
   assign bus.scale_factor = cmd.scale;
   assign bus.shift_amount = cmd.shift;
   assign bus.rsp_valid    = rsp_vld;
   assign bus.rsp_overflow = ovf;
   assign bus.rsp_error    = err;
   assign bus.busy         = active;
endmodule

`default_nettype wire

// File: tb/tb_systolic_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_systolic_tile_sequencer: directed self-checking bench for the tile sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_systolic_tile_sequencer;
   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   systolic_tile_sequencer_if bus ();

   systolic_tile_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer a command in the current cycle (cycle 0); returns in cycle 1.
   task automatic issue(input logic [15:0] k, input logic [7:0] passes,
                        input logic [15:0] base, input logic [31:0] scale,
                        input logic [7:0] shift);
      bus.cmd_k         = k;
      bus.cmd_passes    = passes;
      bus.cmd_base_addr = base;
      bus.cmd_scale     = scale;
      bus.cmd_shift     = shift;
      bus.cmd_valid     = 1'b1;
      chk("cmd_ready_before_accept", bus.cmd_ready, 1'b1);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Advance from cycle 'start' until rsp_valid; optionally answers quant_enable.
   task automatic run_to_rsp(input bit drive_qv, input int start, input int limit,
                             output int rsp_cyc, output int q_cyc);
      rsp_cyc = -1;
      q_cyc   = -1;
      for (int c = start + 1; c <= start + limit; c++) begin
         tick();
         if (bus.quant_enable && q_cyc < 0) q_cyc = c;
         if (bus.rsp_valid) begin
            rsp_cyc = c;
            break;
         end
         bus.quant_valid = drive_qv && bus.quant_enable;
      end
      bus.quant_valid = 1'b0;
      chk("rsp_within_bound", (rsp_cyc >= 0), 1'b1);
   endtask

   task automatic accept_rsp();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("cmd_ready_after_rsp", bus.cmd_ready, 1'b1);
      chk("rsp_valid_dropped", bus.rsp_valid, 1'b0);
   endtask

   int rsp_c, q_c, n_rd, n_clr, n_rsp;
   logic [15:0] rd_addrs [8];
   int          rd_cycs  [8];

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus.cmd_valid = 1'b0;  bus.cmd_k = '0;  bus.cmd_passes = '0;
      bus.cmd_base_addr = '0; bus.cmd_scale = '0; bus.cmd_shift = '0;
      bus.systolic_valid = 1'b0; bus.accum_overflow = 1'b0;
      bus.quant_valid = 1'b0; bus.rsp_ready = 1'b0;
      tick();
      tick();

      chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
      chk("reset_strobes", {bus.op_rd_en, bus.arr_enable, bus.accum_clear,
                            bus.accum_enable, bus.quant_enable, bus.rsp_valid,
                            bus.rsp_overflow, bus.rsp_error, bus.busy}, 9'd0);
      chk("reset_scale", bus.scale_factor, 32'd0);
      chk("reset_shift", bus.shift_amount, 8'd0);
      reset = 1'b0;
      tick();

      // k=4, passes=1, base=0x100: full single-pass timeline
      issue(16'd4, 8'd1, 16'h0100, 32'h1234_5678, 8'd5);
      chk("t1_c1_clear", bus.accum_clear, 1'b1);
      chk("t1_c1_cmd_ready", bus.cmd_ready, 1'b0);
      chk("t1_c1_busy", bus.busy, 1'b1);
      chk("t1_c1_rd_en", bus.op_rd_en, 1'b0);
      chk("t1_scale", bus.scale_factor, 32'h1234_5678);
      chk("t1_shift", bus.shift_amount, 8'd5);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_stream_rd_en", bus.op_rd_en, 1'b1);
         chk("t1_stream_addr", bus.op_rd_addr, 16'h0100 + 16'(i));
         chk("t1_stream_arr_en", bus.arr_enable, (i > 0));
         chk("t1_stream_acc_en_clr", {bus.accum_enable, bus.accum_clear}, 2'b10);
      end
      tick();
      chk("t1_c6_strobes", {bus.accum_enable, bus.quant_enable, bus.op_rd_en, bus.arr_enable}, 4'b1001);
      for (int c = 7; c <= 57; c++) begin
         tick();
         chk("t1_drain_strobes", {bus.accum_enable, bus.quant_enable, bus.op_rd_en, bus.arr_enable}, 4'b1000);
      end
      tick();
      chk("t1_c58_quant", {bus.quant_enable, bus.accum_enable}, 2'b10);
      for (int c = 59; c <= 62; c++) tick();
      chk("t1_c62_still_quant", {bus.quant_enable, bus.rsp_valid}, 2'b10);
      bus.quant_valid = 1'b1;
      tick();
      bus.quant_valid = 1'b0;
      chk("t1_c63_rsp_valid", bus.rsp_valid, 1'b1);
      chk("t1_c63_flags", {bus.rsp_overflow, bus.rsp_error}, 2'b00);
      chk("t1_c63_quant_off", bus.quant_enable, 1'b0);
      chk("t1_c63_cmd_ready", bus.cmd_ready, 1'b0);
      accept_rsp();
      chk("t1_idle_busy", bus.busy, 1'b0);

      // k=3, passes=2, base=0: contiguous addresses across passes, single clear
      issue(16'd3, 8'd2, 16'h0000, 32'd7, 8'd1);
      n_rd = 0; n_clr = 0; n_rsp = 0; rsp_c = -1;
      for (int c = 1; c <= 200; c++) begin
         if (c > 1) tick();
         if (bus.accum_clear) n_clr++;
         if (bus.op_rd_en && n_rd < 8) begin
            rd_addrs[n_rd] = bus.op_rd_addr;
            rd_cycs[n_rd]  = c;
            n_rd++;
         end
         if (bus.rsp_valid) begin
            rsp_c = c;
            break;
         end
         bus.quant_valid = bus.quant_enable;
      end
      bus.quant_valid = 1'b0;
      chk("t2_clear_count", n_clr, 1);
      chk("t2_read_count", n_rd, 6);
      for (int i = 0; i < 6; i++) begin
         chk("t2_addr", rd_addrs[i], 16'(i));
         chk("t2_addr_cycle", rd_cycs[i], (i < 3) ? 2 + i : 54 + i);
      end
      chk("t2_rsp_cycle", rsp_c, 113);
      chk("t2_flags", {bus.rsp_overflow, bus.rsp_error}, 2'b00);
      accept_rsp();
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.rsp_valid) n_rsp++;
      end
      chk("t2_single_rsp", n_rsp, 0);

      // Illegal commands: k=0, then passes=0
      issue(16'd0, 8'd3, 16'h0020, 32'd1, 8'd0);
      chk("t3a_rsp", {bus.rsp_valid, bus.rsp_error}, 2'b11);
      chk("t3a_no_strobes", {bus.accum_clear, bus.op_rd_en, bus.accum_enable, bus.quant_enable}, 4'b0000);
      chk("t3a_busy", bus.busy, 1'b1);
      accept_rsp();
      issue(16'd5, 8'd0, 16'h0020, 32'd1, 8'd0);
      chk("t3b_rsp", {bus.rsp_valid, bus.rsp_error}, 2'b11);
      chk("t3b_no_strobes", {bus.accum_clear, bus.op_rd_en, bus.accum_enable, bus.quant_enable}, 4'b0000);
      accept_rsp();

      // k=2 at base 0xFFFF (wrap), overflow in DRAIN, response held 10 cycles
      issue(16'd2, 8'd1, 16'hFFFF, 32'd3, 8'd2);
      tick();
      chk("t4_addr_ffff", bus.op_rd_addr, 16'hFFFF);
      tick();
      chk("t4_addr_wrap", bus.op_rd_addr, 16'h0000);
      chk("t4_rd_en", bus.op_rd_en, 1'b1);
      for (int c = 4; c <= 10; c++) tick();
      chk("t4_in_drain", {bus.accum_enable, bus.op_rd_en}, 2'b10);
      bus.accum_overflow = 1'b1;
      tick();
      bus.accum_overflow = 1'b0;
      run_to_rsp(1'b1, 11, 200, rsp_c, q_c);
      chk("t4_quant_entry", q_c, 56);
      chk("t4_rsp_cycle", rsp_c, 57);
      for (int i = 0; i < 10; i++) begin
         chk("t4_hold_valid", bus.rsp_valid, 1'b1);
         chk("t4_hold_flags", {bus.rsp_overflow, bus.rsp_error}, 2'b10);
         chk("t4_hold_cmd_ready", bus.cmd_ready, 1'b0);
         tick();
      end
      accept_rsp();

      issue(16'd1, 8'd1, 16'h0010, 32'd9, 8'd3);
      run_to_rsp(1'b1, 1, 200, rsp_c, q_c);
      chk("t4_clean_flags", {bus.rsp_overflow, bus.rsp_error}, 2'b00);
      accept_rsp();

      // quant_valid never arrives: timeout error QUANT_TIMEOUT cycles after entry
      issue(16'd1, 8'd1, 16'h0030, 32'd2, 8'd4);
      run_to_rsp(1'b0, 1, 300, rsp_c, q_c);
      chk("t5_quant_entry", q_c, 55);
      chk("t5_timeout_delay", rsp_c - q_c, 64);
      chk("t5_flags", {bus.rsp_overflow, bus.rsp_error}, 2'b01);
      accept_rsp();

      // Reset in STREAM aborts without a response; next command starts from its base
      issue(16'd8, 8'd1, 16'h0040, 32'hAB, 8'd6);
      tick();
      tick();
      chk("t6_streaming", {bus.op_rd_en, bus.op_rd_addr}, {1'b1, 16'h0041});
      reset = 1'b1;
      tick();
      chk("t6_reset_strobes", {bus.op_rd_en, bus.arr_enable, bus.accum_clear,
                               bus.accum_enable, bus.quant_enable, bus.rsp_valid,
                               bus.busy}, 7'd0);
      chk("t6_reset_cmd_ready", bus.cmd_ready, 1'b1);
      chk("t6_reset_scale", bus.scale_factor, 32'd0);
      reset = 1'b0;
      issue(16'd2, 8'd1, 16'h0080, 32'd5, 8'd7);
      chk("t6_clear", bus.accum_clear, 1'b1);
      tick();
      chk("t6_addr0", {bus.op_rd_en, bus.op_rd_addr}, {1'b1, 16'h0080});
      tick();
      chk("t6_addr1", {bus.op_rd_en, bus.op_rd_addr}, {1'b1, 16'h0081});
      run_to_rsp(1'b1, 3, 200, rsp_c, q_c);
      chk("t6_rsp_cycle", rsp_c, 57);
      chk("t6_flags", {bus.rsp_overflow, bus.rsp_error}, 2'b00);
      accept_rsp();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
